// File: rtl/ram_pin_arbiter.sv
// ram_pin_arbiter: shares the nibble-serial RAM pins between the PPU (priority) and a host port
module ram_pin_arbiter #(
   parameter int RAM_PINS     = 4,
   parameter int ADDR_BITS    = 16,
   parameter int DATA_BITS    = 16,
   parameter int LATENCY      = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ppu_req,
   input  logic [ADDR_BITS-1:0] ppu_addr,
   output logic                 ppu_gnt,
   output logic [DATA_BITS-1:0] ppu_data,
   output logic                 ppu_valid,
   input  logic                 host_req,
   input  logic [ADDR_BITS-1:0] host_addr,
   output logic                 host_gnt,
   output logic [DATA_BITS-1:0] host_data,
   output logic                 host_valid,
   output logic [RAM_PINS-1:0]  addr_pins,
   input  logic [RAM_PINS-1:0]  data_pins
);
   localparam int N_A   = ADDR_BITS / RAM_PINS;
   localparam int N_D   = DATA_BITS / RAM_PINS;
   localparam int L_END = LATENCY > 0 ? LATENCY - 1 : 0;
   localparam int C_AD  = N_A > N_D ? N_A : N_D;
   localparam int C_MAX = C_AD > LATENCY ? C_AD : LATENCY;
   localparam int CW    = $clog2(C_MAX + 1);
   localparam int SW    = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [2:0] {IDLE, HDR, ADDR, WAIT, DATA, DONE} state_t;
   state_t               state;
   logic [CW-1:0]        cnt;
   logic [SW-1:0]        starve;
   logic                 owner;
   logic [ADDR_BITS-1:0] a_sr;
   logic [DATA_BITS-1:0] d_sr;
   logic [DATA_BITS-1:0] d_nx;
   logic                 ppu_win;
   logic                 host_win;
   assign ppu_win  = ppu_req && !(starve == SW'(STARVE_LIMIT) && host_req);
   assign host_win = host_req && !ppu_win;
   assign d_nx     = (d_sr << RAM_PINS) | DATA_BITS'(data_pins);
   // transaction sequencer: arbitration, header, address shift-out, turnaround, data shift-in, delivery
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_pins  <= '0;
         ppu_gnt    <= 1'b0;
         host_gnt   <= 1'b0;
         ppu_valid  <= 1'b0;
         host_valid <= 1'b0;
         ppu_data   <= '0;
         host_data  <= '0;
         starve     <= '0;
         owner      <= 1'b0;
         cnt        <= '0;
         a_sr       <= '0;
         d_sr       <= '0;
      end else begin
         ppu_gnt    <= 1'b0;
         host_gnt   <= 1'b0;
         ppu_valid  <= 1'b0;
         host_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               addr_pins <= '0;
               state     <= IDLE;
               if (ppu_win || host_win) begin
                  state     <= HDR;
                  addr_pins <= RAM_PINS'(1);
                  owner     <= host_win;
                  a_sr      <= host_win ? host_addr : ppu_addr;
                  ppu_gnt   <= ppu_win;
                  host_gnt  <= host_win;
                  if (host_win)
                     starve <= '0;
                  else if (host_req && starve != SW'(STARVE_LIMIT))
                     starve <= starve + 1'b1;
               end
            end
            HDR: begin
               state     <= ADDR;
               cnt       <= '0;
               addr_pins <= a_sr[ADDR_BITS-1 -: RAM_PINS];
               a_sr      <= a_sr << RAM_PINS;
            end
            ADDR: begin
               if (cnt == CW'(N_A - 1)) begin
                  addr_pins <= '0;
                  cnt       <= '0;
                  state     <= LATENCY == 0 ? DATA : WAIT;
               end else begin
                  addr_pins <= a_sr[ADDR_BITS-1 -: RAM_PINS];
                  a_sr      <= a_sr << RAM_PINS;
                  cnt       <= cnt + 1'b1;
               end
            end
            WAIT: begin
               addr_pins <= '0;
               cnt       <= cnt == CW'(L_END) ? '0 : cnt + 1'b1;
               state     <= cnt == CW'(L_END) ? DATA : WAIT;
            end
            DATA: begin
               addr_pins <= '0;
               d_sr      <= d_nx;
               if (cnt == CW'(N_D - 1)) begin
                  state <= DONE;
                  cnt   <= '0;
                  if (owner) begin
                     host_data  <= d_nx;
                     host_valid <= 1'b1;
                  end else begin
                     ppu_data  <= d_nx;
                     ppu_valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               addr_pins <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ram_pin_arbiter.sv
// tb_ram_pin_arbiter: table vectors plus scoreboarded corner sequences for ram_pin_arbiter
module tb_ram_pin_arbiter;
   localparam int N_A = 4;
   localparam int N_D = 4;
   localparam int LAT = 2;
   localparam int SL  = 8;
   localparam int TL  = 1 + N_A + LAT + N_D + 1;
   localparam logic [15:0] KEY = 16'hACDB;
   typedef struct {
      logic        host;
      logic [15:0] addr;
      logic [15:0] data;
   } txn_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ppu_req = 1'b0;
   logic [15:0] ppu_addr = '0;
   logic        ppu_gnt;
   logic [15:0] ppu_data;
   logic        ppu_valid;
   logic        host_req = 1'b0;
   logic [15:0] host_addr = '0;
   logic        host_gnt;
   logic [15:0] host_data;
   logic        host_valid;
   logic [3:0]  addr_pins;
   logic [3:0]  data_pins = '0;
   logic        z_req = 1'b0;
   logic [15:0] z_addr = '0;
   logic        z_gnt;
   logic [15:0] z_data;
   logic        z_valid;
   logic        z_hgnt;
   logic [15:0] z_hdata;
   logic        z_hvalid;
   logic [3:0]  z_pins;
   logic [3:0]  z_dpins = '0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          k = 0;
   bit          active = 1'b0;
   bit          mon_on = 1'b0;
   txn_t        sb[$];
   bit          gq[$];
   txn_t        cur;
   logic [15:0] a_rx = '0;
   logic [15:0] w = '0;
   logic [15:0] e_pd = '0;
   logic [15:0] e_hd = '0;
   txn_t        tv[6];

   ram_pin_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_gnt(ppu_gnt), .ppu_data(ppu_data), .ppu_valid(ppu_valid),
      .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt), .host_data(host_data), .host_valid(host_valid),
      .addr_pins(addr_pins), .data_pins(data_pins)
   );

   ram_pin_arbiter #(.LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .ppu_req(z_req), .ppu_addr(z_addr), .ppu_gnt(z_gnt), .ppu_data(z_data), .ppu_valid(z_valid),
      .host_req(1'b0), .host_addr(16'h0000), .host_gnt(z_hgnt), .host_data(z_hdata), .host_valid(z_hvalid),
      .addr_pins(z_pins), .data_pins(z_dpins)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] nib(input logic [15:0] v, input int i);
      return 4'(v >> (12 - 4 * i));
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // pin-level monitor, RAM model and scoreboard consumer
   always @(negedge clk) begin
      cyc++;
      data_pins = 4'($urandom);
      if (mon_on) begin
         if (active) begin
            k++;
            if (k <= N_A) a_rx = {a_rx[11:0], addr_pins};
            else chk("pins_zero", addr_pins, 0);
            if (k == N_A) chk("addr_stream", a_rx, cur.addr);
            if (k >= 1 + N_A + LAT && k < 1 + N_A + LAT + N_D) begin
               w = a_rx ^ KEY;
               data_pins = nib(w, k - 1 - N_A - LAT);
            end
            chk("ppu_valid", ppu_valid, k == TL - 1 && !cur.host);
            chk("host_valid", host_valid, k == TL - 1 && cur.host);
            if (k == TL - 1) begin
               if (cur.host) e_hd = cur.data;
               else e_pd = cur.data;
               active = 1'b0;
            end
         end else begin
            chk("stray_valid", {ppu_valid, host_valid}, 0);
         end
         if (ppu_gnt || host_gnt) begin
            chk("gnt_onehot", ppu_gnt && host_gnt, 0);
            chk("gnt_overlap", active, 0);
            chk("hdr_nibble", addr_pins, 1);
            gq.push_back(host_gnt);
            chk("gnt_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               chk("gnt_owner", host_gnt, cur.host);
            end
            active = 1'b1;
            k = 0;
            a_rx = '0;
         end else if (!active) begin
            chk("idle_pins", addr_pins, 0);
         end
         chk("ppu_data", ppu_data, e_pd);
         chk("host_data", host_data, e_hd);
         if (!rst_n) begin
            active = 1'b0;
            e_pd = '0;
            e_hd = '0;
         end
      end
   end

   task automatic single(input txn_t t);
      if (t.host) begin
         host_req = 1'b1;
         host_addr = t.addr;
      end else begin
         ppu_req = 1'b1;
         ppu_addr = t.addr;
      end
      sb.push_back(t);
      step();
      chk(t.host ? "host_gnt_c1" : "ppu_gnt_c1", t.host ? host_gnt : ppu_gnt, 1);
      chk("other_gnt_c1", t.host ? ppu_gnt : host_gnt, 0);
      ppu_req = 1'b0;
      host_req = 1'b0;
      ppu_addr = ~t.addr;
      host_addr = ~t.addr;
      repeat (10) step();
      chk("valid_early", {ppu_valid, host_valid}, 0);
      step();
      chk(t.host ? "host_valid_c12" : "ppu_valid_c12", t.host ? host_valid : ppu_valid, 1);
      chk(t.host ? "host_data_c12" : "ppu_data_c12", t.host ? host_data : ppu_data, t.data);
      step();
      chk("back_to_idle", {ppu_gnt, host_gnt, ppu_valid, host_valid, addr_pins}, 0);
   endtask

   initial begin
      bit exp_o[20];
      int sc;
      tv[0] = '{1'b0, 16'h1234, 16'hBEEF};
      tv[1] = '{1'b1, 16'hFFFF, 16'h5324};
      tv[2] = '{1'b0, 16'h0000, 16'hACDB};
      tv[3] = '{1'b1, 16'h8001, 16'h2CDA};
      tv[4] = '{1'b0, 16'hACDB, 16'h0000};
      tv[5] = '{1'b1, 16'h5A5A, 16'hF681};
      repeat (3) step();
      chk("rst_gnt", {ppu_gnt, host_gnt}, 0);
      chk("rst_valid", {ppu_valid, host_valid}, 0);
      chk("rst_pins", addr_pins, 0);
      chk("rst_ppu_data", ppu_data, 0);
      chk("rst_host_data", host_data, 0);
      rst_n = 1'b1;
      mon_on = 1'b1;
      step();
      // table of single transactions, including host-address stability (0xFFFF then 0x0000)
      foreach (tv[i]) begin
         single(tv[i]);
         if (i == 0) chk("host_data_untouched", host_data, 0);
      end
      // simultaneous requests: PPU first, host header immediately after DONE
      ppu_req = 1'b1;
      ppu_addr = 16'h0F0F;
      host_req = 1'b1;
      host_addr = 16'h7777;
      sb.push_back('{1'b0, 16'h0F0F, 16'h0F0F ^ KEY});
      sb.push_back('{1'b1, 16'h7777, 16'h7777 ^ KEY});
      step();
      chk("sim_ppu_gnt", ppu_gnt, 1);
      chk("sim_host_gnt_c1", host_gnt, 0);
      ppu_req = 1'b0;
      repeat (11) step();
      chk("sim_ppu_valid_c12", ppu_valid, 1);
      step();
      chk("sim_host_gnt_c13", host_gnt, 1);
      chk("sim_hdr_c13", addr_pins, 1);
      host_req = 1'b0;
      repeat (11) step();
      chk("sim_host_valid_c24", host_valid, 1);
      step();
      // starvation bound with both requests held
      gq.delete();
      sc = 0;
      for (int i = 0; i < 20; i++) begin
         exp_o[i] = (sc == SL);
         sc = exp_o[i] ? 0 : sc + 1;
         sb.push_back(exp_o[i] ? '{1'b1, 16'h7777, 16'h7777 ^ KEY} : '{1'b0, 16'h0F0F, 16'h0F0F ^ KEY});
      end
      ppu_req = 1'b1;
      host_req = 1'b1;
      repeat (1 + 12 * 19) step();
      ppu_req = 1'b0;
      host_req = 1'b0;
      repeat (12) step();
      chk("starve_grants", gq.size(), 20);
      for (int i = 0; i < 20 && i < gq.size(); i++) chk($sformatf("starve_order_%0d", i), gq[i], exp_o[i]);
      // reset during the second data nibble aborts the transaction
      ppu_req = 1'b1;
      ppu_addr = 16'h4321;
      sb.push_back('{1'b0, 16'h4321, 16'h4321 ^ KEY});
      step();
      chk("abort_gnt", ppu_gnt, 1);
      ppu_req = 1'b0;
      repeat (8) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_pins", addr_pins, 0);
      chk("abort_valid", ppu_valid, 0);
      chk("abort_data", ppu_data, 0);
      repeat (5) step();
      chk("abort_quiet", {ppu_gnt, host_gnt, ppu_valid, host_valid, addr_pins}, 0);
      single('{1'b0, 16'h4321, 16'h4321 ^ KEY});
      // zero-latency build: data follows the address directly, valid in cycle 10
      z_req = 1'b1;
      z_addr = 16'h1234;
      step();
      chk("l0_gnt", z_gnt, 1);
      chk("l0_hdr", z_pins, 1);
      z_req = 1'b0;
      z_addr = 16'h0000;
      for (int c = 2; c <= 9; c++) begin
         step();
         if (c <= 5) chk($sformatf("l0_addr_c%0d", c), z_pins, nib(16'h1234, c - 2));
         else begin
            chk($sformatf("l0_pins_c%0d", c), z_pins, 0);
            z_dpins = nib(16'hBEEF, c - 6);
         end
         chk("l0_valid_early", z_valid, 0);
      end
      step();
      chk("l0_valid_c10", z_valid, 1);
      chk("l0_data", z_data, 16'hBEEF);
      chk("l0_host_quiet", {z_hvalid, z_hgnt}, 0);
      step();
      chk("l0_valid_pulse", z_valid, 0);
      chk("sb_drained", sb.size(), 0);
      chk("no_open_txn", active, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
